// File: rtl/rr_arb_request_frontend_if.sv
// rtl/rr_arb_request_frontend_if.sv - producer, arbiter and consumer signals of the request frontend
//   push_valid/push_data/push_ready : per-line producer handshake, line i data at [i*DATA_W +: DATA_W]
//   req/grant                       : request vector to the arbiter, one-hot grant back
//   out_valid/out_data/out_src/out_ready : registered downstream handshake tagged with source line
//   grant_err                       : one-cycle pulse after an illegal grant
//   slave modport is the frontend, master modport is the environment around it
interface rr_arb_request_frontend_if #(
    parameter int REQUEST_LINES = 4,
    parameter int DATA_W        = 8
);
    localparam int SRC_W = (REQUEST_LINES > 1) ? $clog2(REQUEST_LINES) : 1;

    logic [REQUEST_LINES-1:0]        push_valid;
    logic [REQUEST_LINES*DATA_W-1:0] push_data;
    logic [REQUEST_LINES-1:0]        push_ready;
    logic [REQUEST_LINES-1:0]        req;
    logic [REQUEST_LINES-1:0]        grant;
    logic                            out_valid;
    logic [DATA_W-1:0]               out_data;
    logic [SRC_W-1:0]                out_src;
    logic                            out_ready;
    logic                            grant_err;

    modport slave (
        input  push_valid, push_data, grant, out_ready,
        output push_ready, req, out_valid, out_data, out_src, grant_err
    );

    modport master (
        output push_valid, push_data, grant, out_ready,
        input  push_ready, req, out_valid, out_data, out_src, grant_err
    );
endinterface

// File: rtl/rr_arb_request_frontend.sv
// rtl/rr_arb_request_frontend.sv - per-line FIFOs feeding a round-robin arbiter, one registered output
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : rr_arb_request_frontend_if.slave (push ports, req/grant, output handshake, grant_err)
module rr_arb_request_frontend #(
    parameter int REQUEST_LINES = 4,
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    rr_arb_request_frontend_if.slave bus
);
    localparam int SRC_W = (REQUEST_LINES > 1) ? $clog2(REQUEST_LINES) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]         FULL    = CNT_W'(DEPTH);
    localparam logic [REQUEST_LINES-1:0] ONE_REQ = {{(REQUEST_LINES-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem    [REQUEST_LINES][DEPTH];
    logic [CNT_W-1:0]  count  [REQUEST_LINES];
    logic [PTR_W-1:0]  rd_ptr [REQUEST_LINES];
    logic [PTR_W-1:0]  wr_ptr [REQUEST_LINES];

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SRC_W-1:0]  out_src_q;
    logic              grant_err_q;

    logic                     out_free;
    logic [REQUEST_LINES-1:0] req_c;
    logic [REQUEST_LINES-1:0] push_ready_c;
    logic [REQUEST_LINES-1:0] push_en;
    logic [REQUEST_LINES-1:0] pop_en;
    logic                     grant_onehot;
    logic                     grant_legal;
    logic                     grant_illegal;
    logic [SRC_W-1:0]         grant_idx;
    logic [DATA_W-1:0]        grant_data;

    // req and push_ready depend only on registered counts (plus out_ready for req),
    // so the arbiter's combinational grant never loops back into them.
    always_comb begin
        out_free     = ~out_valid_q | bus.out_ready;
        req_c        = '0;
        push_ready_c = '0;
        for (int i = 0; i < REQUEST_LINES; i++) begin
            push_ready_c[i] = (count[i] != FULL);
            req_c[i]        = (count[i] != '0) & out_free;
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign grant_onehot  = (bus.grant != '0) && ((bus.grant & (bus.grant - ONE_REQ)) == '0);
    assign grant_legal   = grant_onehot && ((bus.grant & req_c) != '0);
    assign grant_illegal = (bus.grant != '0) && !grant_legal;

    assign push_en = bus.push_valid & push_ready_c;
    assign pop_en  = grant_legal ? bus.grant : '0;

    // OR-reduction encoder/mux: exact for a one-hot grant, and only used when the grant is legal.
    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < REQUEST_LINES; i++) begin
            if (bus.grant[i]) begin
                grant_idx  = grant_idx | SRC_W'(i);
                grant_data = grant_data | mem[i][rd_ptr[i]];
            end
        end
    end

    // FIFO storage carries no reset; validity comes from the counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REQUEST_LINES; i++) begin
            if (push_en[i]) begin
                mem[i][wr_ptr[i]] <= bus.push_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REQUEST_LINES; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQUEST_LINES; i++) begin
                if (push_en[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop_en[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                // Push and pop together leave the count unchanged.
                case ({push_en[i], pop_en[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            grant_err_q <= 1'b0;
        end else begin
            grant_err_q <= grant_illegal;
            if (grant_legal) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_data;
                out_src_q   <= grant_idx;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.push_ready = push_ready_c;
    assign bus.req        = req_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.grant_err  = grant_err_q;
endmodule

// File: tb/tb_rr_arb_request_frontend.sv
// tb/tb_rr_arb_request_frontend.sv - scoreboard bench for rr_arb_request_frontend with a round-robin arbiter model
module tb_rr_arb_request_frontend;
    logic clk;
    logic rst;

    rr_arb_request_frontend_if #(.REQUEST_LINES(4), .DATA_W(8)) bus ();

    rr_arb_request_frontend #(
        .REQUEST_LINES(4),
        .DATA_W(8),
        .DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] sb [$];

    // Round-robin arbiter: search starts one past the last granted line.
    logic       use_bench;
    logic [3:0] bench_grant;
    logic [3:0] arb_grant;
    logic [1:0] arb_last;

    always_comb begin
        arb_grant = '0;
        for (int k = 1; k <= 4; k++) begin
            if (arb_grant == '0 && bus.req[(int'(arb_last) + k) % 4]) begin
                arb_grant[(int'(arb_last) + k) % 4] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_last <= 2'd3;
        end else if (!use_bench) begin
            for (int k = 0; k < 4; k++) begin
                if (arb_grant[k]) arb_last <= 2'(k);
            end
        end
    end

    assign bus.grant = use_bench ? bench_grant : arb_grant;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [3:0] v, input logic [31:0] d);
        bus.push_valid = v;
        bus.push_data  = d;
    endtask

    // Monitor: every accepted output transfer is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL out_xfer: got unexpected src=%0d data=%02h expected none",
                         bus.out_src, bus.out_data);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                if ({bus.out_src, bus.out_data} !== e) begin
                    n_err++;
                    $display("FAIL out_xfer: got src=%0d data=%02h expected src=%0d data=%02h",
                             bus.out_src, bus.out_data, e[9:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        use_bench   = 1'b1;
        bench_grant = 4'b0000;
        bus.out_ready = 1'b1;
        drive_push(4'b0000, 32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_req", 32'(bus.req), 32'h0);
        chk("rst_push_ready", 32'(bus.push_ready), 32'hF);
        chk("rst_grant_err", 32'(bus.grant_err), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        step();
        rst = 1'b1;

        // Single push on line 2 with the arbiter connected
        step();
        use_bench = 1'b0;
        drive_push(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
        sb.push_back({2'd2, 8'hA5});
        step();
        drive_push(4'b0000, 32'h0);
        @(negedge clk);
        chk("single_req", 32'(bus.req), 32'h4);
        step();
        @(negedge clk);
        chk("single_valid", 32'(bus.out_valid), 32'h1);
        chk("single_data", 32'(bus.out_data), 32'hA5);
        chk("single_src", 32'(bus.out_src), 32'h2);
        step();
        @(negedge clk);
        chk("single_drop", 32'(bus.out_valid), 32'h0);

        // Fill line 0 with grants held off, fifth push dropped, then drain back-to-back
        step();
        use_bench = 1'b1;
        bench_grant = 4'b0000;
        bus.out_ready = 1'b0;
        drive_push(4'b0001, 32'h10);
        step(); drive_push(4'b0001, 32'h11);
        step(); drive_push(4'b0001, 32'h12);
        step(); drive_push(4'b0001, 32'h13);
        step(); drive_push(4'b0001, 32'h14);
        @(negedge clk);
        chk("full_push_ready", 32'(bus.push_ready), 32'hE);
        step();
        drive_push(4'b0000, 32'h0);
        use_bench = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back({2'd0, 8'h10 + 8'(k)});
        @(negedge clk);
        chk("full_still_full", 32'(bus.push_ready), 32'hE);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk("full_b2b_valid", 32'(bus.out_valid), 32'h1);
        end
        step();
        @(negedge clk);
        chk("full_drained_valid", 32'(bus.out_valid), 32'h0);
        chk("full_drained_ready", 32'(bus.push_ready), 32'hF);

        // Backpressure with lines 1 and 3 holding data
        step();
        use_bench = 1'b1;
        bench_grant = 4'b0000;
        bus.out_ready = 1'b0;
        drive_push(4'b1010, {8'h31, 8'h00, 8'h3C, 8'h00});
        step();
        drive_push(4'b0010, {8'h00, 8'h00, 8'h21, 8'h00});
        step();
        drive_push(4'b0000, 32'h0);
        use_bench = 1'b0;
        sb.push_back({2'd1, 8'h3C});
        sb.push_back({2'd3, 8'h31});
        sb.push_back({2'd1, 8'h21});
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_req", 32'(bus.req), 32'h0);
            chk("bp_data", 32'(bus.out_data), 32'h3C);
            chk("bp_valid", 32'(bus.out_valid), 32'h1);
        end
        step();
        bus.out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_resume_valid", 32'(bus.out_valid), 32'h1);
        chk("bp_resume_data", 32'(bus.out_data), 32'h31);
        repeat (3) step();

        // Illegal grants driven by the bench
        step();
        use_bench = 1'b1;
        bench_grant = 4'b0000;
        drive_push(4'b0011, {8'h00, 8'h00, 8'h41, 8'h40});
        step();
        drive_push(4'b0000, 32'h0);
        bench_grant = 4'b0011;
        @(negedge clk);
        chk("ill_req", 32'(bus.req), 32'h3);
        chk("ill_err_before", 32'(bus.grant_err), 32'h0);
        step();
        bench_grant = 4'b0000;
        @(negedge clk);
        chk("ill_multi_err", 32'(bus.grant_err), 32'h1);
        chk("ill_multi_nopop", 32'(bus.out_valid), 32'h0);
        step();
        bench_grant = 4'b1000;
        @(negedge clk);
        chk("ill_err_one_cycle", 32'(bus.grant_err), 32'h0);
        chk("ill_req_kept", 32'(bus.req), 32'h3);
        step();
        bench_grant = 4'b0000;
        @(negedge clk);
        chk("ill_unreq_err", 32'(bus.grant_err), 32'h1);
        chk("ill_unreq_nopop", 32'(bus.out_valid), 32'h0);
        chk("ill_unreq_req", 32'(bus.req), 32'h3);
        step();
        use_bench = 1'b0;
        sb.push_back({2'd0, 8'h40});
        sb.push_back({2'd1, 8'h41});
        @(negedge clk);
        chk("ill_err_clear", 32'(bus.grant_err), 32'h0);
        repeat (4) step();

        // Round-robin over four lines after a fresh reset
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        use_bench = 1'b1;
        bench_grant = 4'b0000;
        drive_push(4'b1111, {8'h53, 8'h52, 8'h51, 8'h50});
        step();
        drive_push(4'b1111, {8'h5B, 8'h5A, 8'h59, 8'h58});
        step();
        drive_push(4'b0000, 32'h0);
        use_bench = 1'b0;
        for (int k = 0; k < 4; k++) sb.push_back({2'(k), 8'h50 + 8'(k)});
        for (int k = 0; k < 4; k++) sb.push_back({2'(k), 8'h58 + 8'(k)});
        repeat (10) step();
        @(negedge clk);
        chk("rr_done_valid", 32'(bus.out_valid), 32'h0);

        // Refill, then assert reset asynchronously mid-stream
        step();
        use_bench = 1'b1;
        drive_push(4'b1111, {8'h63, 8'h62, 8'h61, 8'h60});
        step();
        drive_push(4'b1111, {8'h6B, 8'h6A, 8'h69, 8'h68});
        step();
        drive_push(4'b0000, 32'h0);
        use_bench = 1'b0;
        sb.push_back({2'd0, 8'h60});
        sb.push_back({2'd1, 8'h61});
        @(posedge clk);
        @(posedge clk);
        #7;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_req", 32'(bus.req), 32'h0);
        chk("arst_push_ready", 32'(bus.push_ready), 32'hF);
        step();
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("arst_flushed_req", 32'(bus.req), 32'h0);
        chk("arst_flushed_valid", 32'(bus.out_valid), 32'h0);
        repeat (3) step();
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_arb_request_frontend.md
Name: rr_arb_request_frontend

Overview:
Requester-side companion to the round-robin mask arbiter. Buffers transactions from REQUEST_LINES independent sources in per-line FIFOs and drives the arbiter's req vector. It consumes the arbiter's one-hot grant in the same cycle, pops the granted line's head entry, and presents it on a single registered valid/ready output tagged with its source index. Sits between N producer ports and one shared downstream consumer.

Parameters:
REQUEST_LINES, 4, number of source lines / req-grant width (>=2)
DATA_W, 8, payload width per transaction
DEPTH, 4, entries per line FIFO (power of 2, >=2)
SRC_W, $clog2(REQUEST_LINES), width of source index (derived, localparam)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
push_valid  input  REQUEST_LINES  per-line push strobe
push_data  input  REQUEST_LINES*DATA_W  per-line payload; line i at bits [i*DATA_W +: DATA_W]
push_ready  output  REQUEST_LINES  per-line FIFO not full
req  output  REQUEST_LINES  request vector to arbiter
grant  input  REQUEST_LINES  one-hot grant from arbiter, combinational from req
out_valid  output  1  output payload valid
out_data  output  DATA_W  granted payload
out_src  output  SRC_W  index of line that supplied out_data
out_ready  input  1  downstream accepts out_data
grant_err  output  1  one-cycle pulse: illegal grant seen previous cycle

Behaviour:
- Reset, rst low, asynchronous: all FIFO counts and rd/wr pointers = 0, out_valid = 0, out_data = 0, out_src = 0, grant_err = 0. FIFO storage is not reset. req = 0 and push_ready = all ones while reset is released.
- Per-line FIFO: count 0..DEPTH (width $clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- push_ready[i] = (count[i] != DEPTH), from registered count only. There is no full-bypass: a pop in the same cycle does not raise push_ready.
- Push on line i when push_valid[i] & push_ready[i]. push_valid with push_ready = 0 is ignored and the data is dropped.
- out_free = ~out_valid | out_ready.
- req[i] = (count[i] != 0) & out_free. This is combinational from registered state and out_ready.
- Legal grant: grant is exactly one-hot AND (grant & req) != 0. On a legal grant for line g:
  - pop line g's head;
  - out_data <= head data; out_src <= g; out_valid <= 1 at the next edge.
- No legal grant and out_valid & out_ready: out_valid <= 0 next edge. out_data and out_src hold.
- out_valid & ~out_ready: out_data, out_src and out_valid stay stable. req is forced to 0, so no pop occurs.
- Illegal grant:
  - Condition: grant != 0 and either not one-hot, or grant has a bit where req = 0.
  - Response: no pop, out regs follow the no-grant rule, grant_err = 1 for exactly the next cycle.
- Simultaneous push and pop on the same line: count unchanged, both pointers advance. This is legal at count = 1, so the FIFO never goes empty.
- Ordering: FIFO order within a line. Inter-line order is decided solely by the arbiter.
- Latency: push accepted at edge t -> req[i] high in cycle t+1 -> if granted in that cycle, out_valid high after edge t+2.
- Throughput: one transaction per cycle with out_ready held high.
- Reset asserted mid-operation: all buffered entries are discarded immediately. out_valid drops asynchronously.
- Width rule: when REQUEST_LINES is a power of 2, out_src fully encodes the line. The one-hot-to-index encoder is an OR-reduction of bit indices, not a priority encoder.

Test Plan:
- Reset: hold rst = 0 for 3 cycles, push_valid = 0 -> out_valid = 0, req = 4'b0000, push_ready = 4'b1111, grant_err = 0.
- Single push: line 2 pushes 0xA5 at t, real arbiter connected -> req = 4'b0100 at t+1; out_valid = 1, out_data = 0xA5, out_src = 2 after t+2.
- Full/order: out_ready = 0, line 0 pushes 0x10, 0x11, 0x12, 0x13, 0x14 on consecutive cycles -> push_ready[0] = 0 after the 4th push, 0x14 dropped; then out_ready = 1 -> outputs 0x10, 0x11, 0x12, 0x13 back-to-back, all with out_src = 0.
- Backpressure: out_valid = 1, out_data = 0x3C, out_ready = 0 for 5 cycles with lines 1 and 3 non-empty -> req = 0, out_data = 0x3C stable, counts unchanged; on release, transfer resumes next cycle.
- Illegal grant (bench-driven grant): req = 4'b0011, grant = 4'b0011 -> grant_err = 1 for one cycle, counts unchanged. Then grant = 4'b1000 while req[3] = 0 -> grant_err pulse, no pop.
- Round-robin with async reset: lines 0–3 each hold 2 entries, real arbiter, out_ready = 1 -> out_src sequence 0, 1, 2, 3, 0, 1, 2, 3. Reset asserted mid-stream -> out_valid = 0 immediately and all counts = 0.
